// File: rtl/exposure_sequencer.sv
// Wafer exposure sequencer: load -> align -> env check -> NUM_FIELDS scans -> unload.
// Every handshake wait has a watchdog. A scan that times out is retried through
// ENV_WAIT so the scan commands drop for at least one cycle. Interlock and
// environment faults abort with a cause code that survives until the next start.
module exposure_sequencer #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_W    = 4,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = 8,
  parameter int MAX_RETRY  = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,          // async, active low
  input  logic               start_op_i,
  input  logic               clear_err_i,
  input  logic               safety_sensor_i,
  input  logic               env_ok_i,
  input  logic               wl_done_i,
  input  logic               rl_done_i,
  input  logic               ws_done_i,
  input  logic               rs_done_i,
  output logic               cmd_wl_load_o,
  output logic               cmd_rl_load_o,
  output logic               cmd_ws_align_o,
  output logic               cmd_ws_scan_o,
  output logic               cmd_rs_scan_o,
  output logic               cmd_source_active_o,
  output logic               cmd_wl_unload_o,
  output logic [3:0]         process_state_o,
  output logic [FIELD_W-1:0] field_idx_o,
  output logic               busy_o,
  output logic               error_o,
  output logic [3:0]         error_code_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_ALIGN    = 4'd2,
    S_ENV_WAIT = 4'd3,
    S_EXPOSE   = 4'd4,
    S_STEP     = 4'd5,
    S_UNLOAD   = 4'd6,
    S_DONE     = 4'd7,
    S_ABORT    = 4'd8
  } state_e;

  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(NUM_FIELDS - 1);
  localparam logic [1:0]         RETRY_MAX  = 2'(MAX_RETRY);
  localparam logic [3:0]         CODE_SCAN  = 4'h4;
  localparam logic [3:0]         CODE_ENV   = 4'hE;
  localparam logic [3:0]         CODE_ILK   = 4'hF;

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic [1:0]         retry_q, retry_d;
  logic [3:0]         code_q, code_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               stk_a_q, stk_a_d;
  logic               stk_b_q, stk_b_d;

  logic pulse_a, pulse_b, done_a, done_b, timeout, in_run, waiting, entry;

  // Completion pulses of the two-party handshakes and the sticky capture view
  always_comb begin
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    case (state_q)
      S_LOAD:   begin pulse_a = wl_done_i; pulse_b = rl_done_i; end
      S_EXPOSE: begin pulse_a = ws_done_i; pulse_b = rs_done_i; end
      default:  ;
    endcase
    done_a  = stk_a_q | pulse_a;
    done_b  = stk_b_q | pulse_b;
    timeout = (wd_q == TO_LAST);
    in_run  = (state_q != S_IDLE) && (state_q != S_ABORT);
    waiting = state_q inside {S_LOAD, S_ALIGN, S_ENV_WAIT, S_EXPOSE, S_UNLOAD};
  end

  // Next state: interlock > env drop > completion > timeout
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    retry_d = retry_q;
    code_d  = code_q;
    if (in_run && safety_sensor_i) begin
      state_d = S_ABORT;
      code_d  = CODE_ILK;
    end else begin
      case (state_q)
        S_IDLE: if (start_op_i && !safety_sensor_i) begin
          state_d = S_LOAD;
          field_d = '0;
          retry_d = '0;
          code_d  = '0;
        end
        S_LOAD:
          if (done_a && done_b) state_d = S_ALIGN;
          else if (timeout) begin state_d = S_ABORT; code_d = 4'(S_LOAD); end
        S_ALIGN:
          if (ws_done_i) state_d = S_ENV_WAIT;
          else if (timeout) begin state_d = S_ABORT; code_d = 4'(S_ALIGN); end
        S_ENV_WAIT:
          if (env_ok_i) state_d = S_EXPOSE;
          else if (timeout) begin state_d = S_ABORT; code_d = 4'(S_ENV_WAIT); end
        S_EXPOSE:
          if (!env_ok_i) begin
            state_d = S_ABORT;
            code_d  = CODE_ENV;
          end else if (done_a && done_b) begin
            state_d = S_STEP;
          end else if (timeout) begin
            if (retry_q < RETRY_MAX) begin
              state_d = S_ENV_WAIT;   // drops scan commands, field_idx kept
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = S_ABORT;
              code_d  = CODE_SCAN;
            end
          end
        S_STEP:
          if (field_q == FIELD_LAST) state_d = S_UNLOAD;
          else begin
            state_d = S_EXPOSE;
            field_d = field_q + 1'b1;
            retry_d = '0;
          end
        S_UNLOAD:
          if (wl_done_i) state_d = S_DONE;
          else if (timeout) begin state_d = S_ABORT; code_d = 4'(S_UNLOAD); end
        S_DONE:  state_d = S_IDLE;
        S_ABORT: if (clear_err_i && !safety_sensor_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Watchdog and sticky done bits restart on every state entry
  always_comb begin
    entry   = (state_d != state_q);
    stk_a_d = entry ? 1'b0 : (stk_a_q | pulse_a);
    stk_b_d = entry ? 1'b0 : (stk_b_q | pulse_b);
    if (entry)                     wd_d = '0;
    else if (waiting && !timeout)  wd_d = wd_q + 1'b1;
    else                           wd_d = wd_q;
  end

  // State, counters and registered command/status decode of the next state
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q             <= S_IDLE;
      field_q             <= '0;
      retry_q             <= '0;
      code_q              <= '0;
      wd_q                <= '0;
      stk_a_q             <= 1'b0;
      stk_b_q             <= 1'b0;
      cmd_wl_load_o       <= 1'b0;
      cmd_rl_load_o       <= 1'b0;
      cmd_ws_align_o      <= 1'b0;
      cmd_ws_scan_o       <= 1'b0;
      cmd_rs_scan_o       <= 1'b0;
      cmd_source_active_o <= 1'b0;
      cmd_wl_unload_o     <= 1'b0;
      busy_o              <= 1'b0;
      error_o             <= 1'b0;
    end else begin
      state_q             <= state_d;
      field_q             <= field_d;
      retry_q             <= retry_d;
      code_q              <= code_d;
      wd_q                <= wd_d;
      stk_a_q             <= stk_a_d;
      stk_b_q             <= stk_b_d;
      cmd_wl_load_o       <= (state_d == S_LOAD);
      cmd_rl_load_o       <= (state_d == S_LOAD);
      cmd_ws_align_o      <= (state_d == S_ALIGN);
      cmd_ws_scan_o       <= (state_d == S_EXPOSE);
      cmd_rs_scan_o       <= (state_d == S_EXPOSE);
      cmd_source_active_o <= (state_d == S_EXPOSE);
      cmd_wl_unload_o     <= (state_d == S_UNLOAD);
      busy_o              <= !(state_d inside {S_IDLE, S_DONE, S_ABORT});
      error_o             <= (state_d == S_ABORT);
    end
  end

  assign process_state_o = state_q;
  assign field_idx_o     = field_q;
  assign error_code_o    = code_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer with NUM_FIELDS=3, TIMEOUT=16, MAX_RETRY=1.
module tb_exposure_sequencer;

  localparam int NF = 3;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_op = 0, clear_err = 0, safety = 0, env_ok = 1;
  logic wl_done = 0, rl_done = 0, ws_done = 0, rs_done = 0;
  logic cmd_wl_load, cmd_rl_load, cmd_ws_align, cmd_ws_scan, cmd_rs_scan;
  logic cmd_src, cmd_wl_unload, busy, error;
  logic [3:0] pstate, ecode;
  logic [FW-1:0] fidx;

  int total = 0;
  int bad   = 0;
  int windows = 0;
  logic src_prev = 1'b0;

  exposure_sequencer #(.NUM_FIELDS(NF), .FIELD_W(FW), .TIMEOUT(16), .TO_W(8), .MAX_RETRY(1)) dut (
    .clk_i(clk), .reset_i(reset), .start_op_i(start_op), .clear_err_i(clear_err),
    .safety_sensor_i(safety), .env_ok_i(env_ok),
    .wl_done_i(wl_done), .rl_done_i(rl_done), .ws_done_i(ws_done), .rs_done_i(rs_done),
    .cmd_wl_load_o(cmd_wl_load), .cmd_rl_load_o(cmd_rl_load), .cmd_ws_align_o(cmd_ws_align),
    .cmd_ws_scan_o(cmd_ws_scan), .cmd_rs_scan_o(cmd_rs_scan), .cmd_source_active_o(cmd_src),
    .cmd_wl_unload_o(cmd_wl_unload), .process_state_o(pstate), .field_idx_o(fidx),
    .busy_o(busy), .error_o(error), .error_code_o(ecode)
  );

  always #5 clk = ~clk;

  // count rising edges of the light-source command
  always @(negedge clk) begin
    if (cmd_src && !src_prev) windows <= windows + 1;
    src_prev <= cmd_src;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] cmds();
    return {cmd_wl_load, cmd_rl_load, cmd_ws_align, cmd_ws_scan, cmd_rs_scan, cmd_src, cmd_wl_unload};
  endfunction

  // IDLE -> LOAD (pulses split over cycles) -> ALIGN
  task automatic run_to_align();
    start_op = 1; tick(); start_op = 0;
    chk("load_state", pstate, 1);
    chk("load_cmds", cmds(), 7'b1100000);
    chk("load_busy", busy, 1);
    chk("load_field_clr", fidx, 0);
    chk("load_code_clr", ecode, 0);
    tick(); wl_done = 1; tick(); wl_done = 0;
    chk("load_sticky_wait", pstate, 1);
    tick(); rl_done = 1; tick(); rl_done = 0;
    chk("align_state", pstate, 2);
    chk("align_cmds", cmds(), 7'b0010000);
  endtask

  task automatic run_to_expose();
    run_to_align();
    tick(); ws_done = 1; tick(); ws_done = 0;
    chk("env_state", pstate, 3);
    tick();
    chk("exp0_state", pstate, 4);
    chk("exp0_cmds", cmds(), 7'b0001110);
    chk("exp0_field", fidx, 0);
  endtask

  // one field: ws then rs in separate cycles -> STEP -> next
  task automatic expose_ok(input int f);
    chk("exp_state", pstate, 4);
    chk("exp_field", fidx, f);
    chk("exp_src", cmd_src, 1);
    ws_done = 1; tick(); ws_done = 0;
    chk("exp_sticky_wait", pstate, 4);
    rs_done = 1; tick(); rs_done = 0;
    chk("step_state", pstate, 5);
    chk("step_cmds", cmds(), 7'b0000000);
    tick();
  endtask

  task automatic finish_unload();
    chk("unload_state", pstate, 6);
    chk("unload_cmds", cmds(), 7'b0000001);
    wl_done = 1; tick(); wl_done = 0;
    chk("done_state", pstate, 7);
    chk("done_busy", busy, 0);
    tick();
    chk("idle_state", pstate, 0);
    chk("end_field", fidx, NF - 1);
    chk("end_error", error, 0);
  endtask

  initial begin
    int w0;
    #1;
    chk("rst_state", pstate, 0);
    chk("rst_cmds", cmds(), 0);
    chk("rst_field", fidx, 0);
    chk("rst_flags", {busy, error, ecode}, 0);
    tick(2);
    reset = 1;
    tick();

    // nominal run
    w0 = windows;
    run_to_expose();
    expose_ok(0);
    expose_ok(1);
    expose_ok(2);
    finish_unload();
    chk("nom_windows", windows - w0, 3);

    // scan retry on field 1
    run_to_expose();
    expose_ok(0);
    ws_done = 1; tick(); ws_done = 0;
    tick(14);
    chk("retry_last_wait", pstate, 4);
    tick();
    chk("retry_env", pstate, 3);
    chk("retry_src_drop", cmd_src, 0);
    chk("retry_field_env", fidx, 1);
    tick();
    chk("retry_reexp", pstate, 4);
    chk("retry_field", fidx, 1);
    rs_done = 1; tick(); rs_done = 0;
    chk("retry_sticky_clr", pstate, 4);
    ws_done = 1; tick(); ws_done = 0;
    chk("retry_step", pstate, 5);
    tick();
    expose_ok(2);
    finish_unload();

    // retry exhausted on field 0
    run_to_expose();
    tick(16);
    chk("exh_env", pstate, 3);
    tick();
    chk("exh_reexp", pstate, 4);
    tick(15);
    chk("exh_last_wait", pstate, 4);
    tick();
    chk("exh_abort", pstate, 8);
    chk("exh_code", ecode, 4);
    chk("exh_cmds", cmds(), 0);
    chk("exh_flags", {busy, error}, 2'b01);
    clear_err = 1; tick(); clear_err = 0;
    chk("exh_idle", pstate, 0);
    chk("exh_code_hold", ecode, 4);
    chk("exh_err_clr", error, 0);

    // interlock during field 2
    run_to_expose();
    expose_ok(0);
    expose_ok(1);
    chk("ilk_field", fidx, 2);
    safety = 1; tick();
    chk("ilk_abort", pstate, 8);
    chk("ilk_code", ecode, 4'hF);
    chk("ilk_cmds", cmds(), 0);
    clear_err = 1; tick(2);
    chk("ilk_hold", pstate, 8);
    safety = 0; tick(); clear_err = 0;
    chk("ilk_idle", pstate, 0);
    chk("ilk_code_hold", ecode, 4'hF);

    // LOAD timeout
    start_op = 1; tick(); start_op = 0;
    tick(15);
    chk("lto_last_wait", pstate, 1);
    tick();
    chk("lto_abort", pstate, 8);
    chk("lto_code", ecode, 1);
    clear_err = 1; tick(); clear_err = 0;
    chk("lto_idle", pstate, 0);

    // completion beats timeout; env drop beats completion
    run_to_align();
    tick(15);
    chk("sim_align_wait", pstate, 2);
    ws_done = 1; tick(); ws_done = 0;
    chk("sim_done_wins", pstate, 3);
    tick();
    chk("sim_expose", pstate, 4);
    env_ok = 0; ws_done = 1; tick(); ws_done = 0; env_ok = 1;
    chk("sim_env_abort", pstate, 8);
    chk("sim_env_code", ecode, 4'hE);
    clear_err = 1; tick(); clear_err = 0;
    chk("sim_idle", pstate, 0);

    // async reset mid-LOAD
    start_op = 1; tick(); start_op = 0;
    chk("ar_load", pstate, 1);
    #2 reset = 0;
    #1;
    chk("ar_state", pstate, 0);
    chk("ar_cmds", cmds(), 0);
    chk("ar_busy", busy, 0);
    #1 reset = 1;
    start_op = 1; tick(); start_op = 0;
    chk("ar_restart", pstate, 1);
    chk("ar_restart_cmd", cmd_wl_load, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Parametrised successor to the scanner top-level controller.
- Sequences one wafer through load, align, environment check, NUM_FIELDS step-and-scan exposures, and unload.
- Adds per-state timeout watchdogs, per-field exposure retry, interlock/environment abort with error codes, and field progress reporting.
- Drives the existing loader, stage and light-source subsystems through level command / pulse-done handshakes.

Parameters:
- NUM_FIELDS, 8, exposure fields per wafer (2..2**FIELD_W).
- FIELD_W, 4, width of field index.
- TIMEOUT, 64, max cycles spent waiting in any handshake state (2..2**TO_W).
- TO_W, 8, watchdog counter width.
- MAX_RETRY, 2, re-exposure attempts per field after a scan timeout (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_op  in  1  start request; sampled in IDLE only.
- clear_err  in  1  leaves ABORT.
- safety_sensor  in  1  1 = interlock tripped.
- env_ok  in  1  environment within limits.
- wl_done  in  1  wafer loader op-complete pulse.
- rl_done  in  1  reticle loader op-complete pulse.
- ws_done  in  1  wafer stage op-complete pulse.
- rs_done  in  1  reticle stage op-complete pulse.
- cmd_wl_load  out  1  held high in LOAD.
- cmd_rl_load  out  1  held high in LOAD.
- cmd_ws_align  out  1  held high in ALIGN.
- cmd_ws_scan  out  1  held high in EXPOSE.
- cmd_rs_scan  out  1  held high in EXPOSE.
- cmd_source_active  out  1  held high in EXPOSE.
- cmd_wl_unload  out  1  held high in UNLOAD.
- process_state  out  4  current state encoding.
- field_idx  out  FIELD_W  field being / last exposed.
- busy  out  1  state not IDLE, DONE or ABORT.
- error  out  1  high in ABORT.
- error_code  out  4  abort cause; holds until the next start.

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, counters 0, sticky done bits 0.
- State encoding: IDLE=0, LOAD=1, ALIGN=2, ENV_WAIT=3, EXPOSE=4, STEP=5, UNLOAD=6, DONE=7, ABORT=8.
- Outputs are registered and decoded from the state register; commands are valid in the cycle the state is entered.
- IDLE -> LOAD: start_op=1 and safety_sensor=0. On this transition field_idx, retry count and error_code are cleared.
- LOAD: sticky bits capture wl_done and rl_done; pulses may arrive in different cycles. Both set -> ALIGN.
- ALIGN: ws_done -> ENV_WAIT.
- ENV_WAIT: env_ok=1 -> EXPOSE.
- EXPOSE: sticky bits capture ws_done and rs_done; both set -> STEP.
- STEP (1 cycle): if field_idx==NUM_FIELDS-1 -> UNLOAD; else field_idx+1, retry count cleared, -> EXPOSE.
- UNLOAD: wl_done -> DONE.
- DONE (1 cycle) -> IDLE.
- Sticky bits clear on every state entry, including re-entry of EXPOSE.
- Watchdog: cycle counter resets to 0 on each state entry. Timeout fires when counter==TIMEOUT-1 and the completion condition is false in that cycle.
- Timeout in EXPOSE with retry<MAX_RETRY: retry+1 and pass through STEP-less re-entry, i.e. EXPOSE -> ENV_WAIT (commands drop for at least 1 cycle) -> EXPOSE. field_idx is unchanged.
- Timeout in EXPOSE with retry==MAX_RETRY: ABORT, error_code=4.
- Timeout in any other wait state: ABORT, error_code = state encoding (1, 2, 3 or 6).
- Interlock: safety_sensor=1 in any busy state or DONE -> ABORT next edge, error_code=4'hF.
- env_ok=0 while in EXPOSE -> ABORT, error_code=4'hE.
- Priority per cycle: interlock > env drop > completion > timeout.
- ABORT: all cmd_* low, error=1. clear_err=1 and safety_sensor=0 -> IDLE; error_code is retained.
- start_op outside IDLE is ignored; a held start_op re-arms only after DONE -> IDLE.
- field_idx never exceeds NUM_FIELDS-1; no wrap.

Test Plan:
Bench parameters: NUM_FIELDS=3, TIMEOUT=16, MAX_RETRY=1.
- Nominal: start; wl_done and rl_done in cycles 3 and 5; responses after 2 cycles each -> states 1,2,3,(4,5)x3,6,7,0; field_idx ends at 2; error=0; cmd_source_active high in exactly 3 EXPOSE windows.
- Scan retry: withhold rs_done on field 1 for 16 cycles, then respond -> EXPOSE -> ENV_WAIT -> EXPOSE with field_idx=1; run completes with error=0.
- Retry exhausted: withhold rs_done on field 0 for 2x16 cycles -> ABORT, error_code=4, all commands 0.
- Interlock mid-scan: safety_sensor=1 in EXPOSE field 2 -> next cycle state=8, error_code=F; clear_err held while safety_sensor=1 stays in ABORT; after release -> IDLE.
- Simultaneous events: ws_done and timeout in the same cycle -> completion wins; env_ok=0 and ws_done together in EXPOSE -> ABORT, code E.
- Async reset asserted mid-LOAD -> outputs 0 immediately, before the next clk edge; start_op after release is accepted.
